// File: rtl/event_sched_pkg.sv
// Shared types and default parameters for the delayed event scheduler.
package event_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StFire
  } sched_state_e;

  localparam int unsigned DefDepth  = 4;
  localparam int unsigned DefDelayW = 8;
  localparam int unsigned DefCntW   = 16;

endpackage

// File: rtl/event_req_fifo.sv
// Synchronous request FIFO holding per-event delay values; flush empties it in one edge.
module event_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en, pop_en;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_en) - CntW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/event_delay_scheduler.sv
// Queues delayed trigger requests and fires a one-cycle pulse per request, in order,
// each after its own delay counted from when it is loaded into the timer.
module event_delay_scheduler
  import event_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned DELAY_W = DefDelayW,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [DELAY_W-1:0]           req_delay,
  output logic                         evt_pulse,
  output logic [CNT_W-1:0]             evt_count,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         busy
);

  sched_state_e       state_q;
  logic [DELAY_W-1:0] cnt_q;
  logic               evt_pulse_q;
  logic [CNT_W-1:0]   evt_count_q;

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [DELAY_W-1:0] head_delay;

  event_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DELAY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (req_valid && req_ready),
    .wdata (req_delay),
    .pop   (fifo_pop),
    .rdata (head_delay),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  assign req_ready = !fifo_full;
  assign fifo_pop  = !flush && !fifo_empty && (state_q == StIdle || state_q == StFire);
  assign busy      = (state_q != StIdle) || !fifo_empty;
  assign evt_pulse = evt_pulse_q;
  assign evt_count = evt_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      evt_pulse_q <= 1'b0;
      evt_count_q <= '0;
    end else if (flush) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      evt_pulse_q <= 1'b0;
    end else begin
      evt_pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q <= StCount;
            cnt_q   <= head_delay;
          end
        end
        StCount: begin
          if (cnt_q == '0) begin
            state_q     <= StFire;
            evt_pulse_q <= 1'b1;
            evt_count_q <= evt_count_q + CNT_W'(1);
          end else begin
            cnt_q <= cnt_q - DELAY_W'(1);
          end
        end
        StFire: begin
          if (!fifo_empty) begin
            state_q <= StCount;
            cnt_q   <= head_delay;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/event_delay_scheduler.md
EVENT_DELAY_SCHEDULER -- requirements
Module: event_delay_scheduler

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, request queue entries (power of two, >=2); DELAY_W, default 8, delay field width; CNT_W, default 16, event counter width.
REQ-002 Port clk SHALL be input, 1 bit: single clock; all state updates on rising edge.
REQ-003 Port rst_n SHALL be input, 1 bit: asynchronous active-low reset.
REQ-004 Port flush SHALL be input, 1 bit: synchronous clear of queue and timer.
REQ-005 Port req_valid SHALL be input, 1 bit: trigger request offered.
REQ-006 Port req_ready SHALL be output, 1 bit: queue can accept a request.
REQ-007 Port req_delay SHALL be input, DELAY_W bits: cycles to wait before firing this event.
REQ-008 Port evt_pulse SHALL be output, 1 bit: registered one-cycle event trigger to the downstream event consumer.
REQ-009 Port evt_count SHALL be output, CNT_W bits: total events fired, wrapping.
REQ-010 Port pending SHALL be output, $clog2(DEPTH+1) bits: queued requests not yet loaded into the timer.
REQ-011 Port busy SHALL be output, 1 bit: timer is counting, or pending != 0.

Function
REQ-012 Accept SHALL occur on an edge where req_valid && req_ready; req_ready SHALL equal (pending != DEPTH), independent of a same-cycle pop.
REQ-013 Requests SHALL fire strictly in acceptance order (FIFO); delays SHALL run back-to-back, each timed from its own load.
REQ-014 FSM states SHALL be IDLE, COUNT and FIRE.
REQ-015 IDLE -> COUNT SHALL occur when pending != 0: pop head, counter <= head delay.
REQ-016 COUNT SHALL decrement the counter when it is nonzero; counter == 0 SHALL cause COUNT -> FIRE.
REQ-017 FIRE SHALL assert evt_pulse for exactly one cycle, then enter COUNT (popping the next head) if pending != 0, else IDLE.
REQ-018 Latency: a request accepted at edge T into an idle, empty block SHALL produce evt_pulse high for the cycle following edge T+d+2 (d = req_delay); d = 0 SHALL fire after 2 edges.
REQ-019 Back-to-back firing: the next event with delay d2 SHALL pulse d2+2 edges after the previous pulse edge.
REQ-020 evt_count SHALL increment in the same edge that sets evt_pulse; 2^CNT_W-1 SHALL wrap to 0.
REQ-021 Simultaneous push and pop SHALL leave pending unchanged; a push into a full queue SHALL NOT occur (req_ready low).
REQ-022 flush SHALL take priority over push, pop and fire: on that edge empty the queue, return to IDLE, and force evt_pulse to 0; evt_count SHALL be retained; a same-cycle request SHALL be dropped.
REQ-023 Pointer wrap at DEPTH SHALL be seamless; order SHALL be preserved across wrap.
REQ-024 Outputs SHALL be glitch-free registered values, except req_ready, pending and busy, which are derived from registered state only.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, counter 0, queue empty, evt_pulse 0, evt_count 0, pending 0, busy 0, req_ready 1.
REQ-026 Reset mid-COUNT or mid-FIRE SHALL discard all queued and in-flight events; no pulse SHALL be emitted after release until a new request is accepted.
REQ-027 Reset deassertion SHALL be synchronised externally; the block SHALL accept a request on the first edge after release.

Structure
REQ-028 Package event_sched_pkg SHALL hold the state enum type (IDLE/COUNT/FIRE) and default parameter constants.
REQ-029 The queue SHALL be a sub-module event_req_fifo (sync FIFO, DEPTH x DELAY_W, push/pop/full/empty/count, flush input).
REQ-030 The timer/FSM SHALL reside in event_delay_scheduler; total RTL SHALL be about 150-250 lines.

Verification
REQ-031 Single request d=5 at edge 10 SHALL produce evt_pulse high after edge 17 for one cycle, evt_count 0->1 and busy low after edge 18.
REQ-032 Three requests d=0,3,1 back-to-back SHALL produce pulses after edges T+2, T+7 and T+10, with evt_count = 3.
REQ-033 Five requests with DEPTH=4 and the timer stalled on d=255 SHALL give req_ready low after the 4th queued entry, the 5th held until a pop, and all five fired in order.
REQ-034 flush asserted during COUNT with 2 pending SHALL give no further pulses, pending 0, evt_count unchanged, and state IDLE on the next edge.
REQ-035 rst_n pulsed low mid-COUNT SHALL clear all outputs immediately (async), with no pulse after release.
REQ-036 evt_count preset to 0xFFFF via 65535 events (or forced) SHALL give next pulse -> evt_count 0x0000.
